// File: rtl/video_pattern_gen.sv
// Composite-video test-pattern generator with raster timing,
// four selectable patterns and a first-order delta-sigma DAC.
module video_pattern_gen #(
  parameter DW          = 10,
  parameter H_TOTAL     = 780,
  parameter V_TOTAL     = 263,
  parameter H_SYNC      = 58,
  parameter H_ACT_START = 128,
  parameter H_ACT_LEN   = 640,
  parameter V_SYNC      = 3,
  parameter V_ACT_START = 21,
  parameter V_ACT_LEN   = 240,
  parameter PEDE        = 205,
  parameter BAR_STEP    = 85
) (
  input  logic          CK_i,
  input  logic          RST_i,
  input  logic          CK_EE_i,
  input  logic [1:0]    MODE_i,
  input  logic [DW-1:0] LEVEL_i,
  output logic [DW-1:0] VIDEOs_o,
  output logic          VIDEO_o,
  output logic          XSYNC_o,
  output logic          XBLK_o,
  output logic [7:0]    FCTRs_o,
  output logic          FRAME_START_o
);

  localparam HW = $clog2(H_TOTAL);
  localparam VW = $clog2(V_TOTAL);
  localparam BW = H_ACT_LEN / 8;

  logic [HW-1:0] hctr;
  logic [VW-1:0] vctr;
  logic [7:0]    fctr;
  logic [1:0]    mode_l;

  logic        h_end;
  logic        v_end;
  logic        at_origin;
  logic [31:0] h32;
  logic [31:0] v32;
  logic [15:0] x0;
  logic [7:0]  y0;
  logic        sync0;
  logic        act0;

  assign h_end     = hctr == HW'(H_TOTAL - 1);
  assign v_end     = vctr == VW'(V_TOTAL - 1);
  assign at_origin = (hctr == '0) && (vctr == '0);
  assign h32       = 32'(hctr);
  assign v32       = 32'(vctr);
  assign x0        = 16'(h32 - H_ACT_START);
  assign y0        = 8'(v32 - V_ACT_START);

  always_comb begin
    sync0 = 1'b0;
    if (v32 < V_SYNC)
      sync0 = h32 < (H_TOTAL - H_SYNC);
    else
      sync0 = h32 < H_SYNC;
    act0 = (h32 >= H_ACT_START) &&
           (h32 < H_ACT_START + H_ACT_LEN) &&
           (v32 >= V_ACT_START) &&
           (v32 < V_ACT_START + V_ACT_LEN);
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      hctr   <= '0;
      vctr   <= '0;
      fctr   <= '0;
      mode_l <= '0;
    end else if (CK_EE_i) begin
      if (at_origin)
        mode_l <= MODE_i;
      if (h_end) begin
        hctr <= '0;
        if (v_end) begin
          vctr <= '0;
          fctr <= fctr + 8'd1;
        end else begin
          vctr <= vctr + VW'(1);
        end
      end else begin
        hctr <= hctr + HW'(1);
      end
    end
  end

  logic        s1_sync;
  logic        s1_act;
  logic        s1_first;
  logic [7:0]  s1_xh;
  logic [7:0]  s1_y;
  logic [7:0]  s1_f;
  logic [15:0] s1_bpix;
  logic [2:0]  s1_bar;

  // Bar index runs free outside the active area; it restarts at x=0.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      s1_sync  <= 1'b0;
      s1_act   <= 1'b0;
      s1_first <= 1'b0;
      s1_xh    <= '0;
      s1_y     <= '0;
      s1_f     <= '0;
      s1_bpix  <= '0;
      s1_bar   <= '0;
    end else if (CK_EE_i) begin
      s1_sync  <= sync0;
      s1_act   <= act0;
      s1_first <= at_origin;
      s1_xh    <= x0[8:1];
      s1_y     <= y0;
      s1_f     <= fctr;
      if (x0 == '0) begin
        s1_bpix <= '0;
        s1_bar  <= '0;
      end else if (s1_bpix == 16'(BW - 1)) begin
        s1_bpix <= '0;
        s1_bar  <= s1_bar + 3'd1;
      end else begin
        s1_bpix <= s1_bpix + 16'd1;
      end
    end
  end

  logic [7:0]    ramp;
  logic [DW-1:0] pat;
  logic [DW:0]   sum;
  logic [DW-1:0] lvl;

  always_comb begin
    ramp = s1_xh + s1_y + s1_f;
    pat  = '0;
    unique case (mode_l)
      2'd0: pat = DW'({ramp, 1'b0});
      2'd1: pat = DW'(32'(s1_bar) * BAR_STEP);
      2'd2: pat = LEVEL_i;
      2'd3: pat = (s1_xh[4] ^ s1_y[5] ^ s1_f[0]) ?
                  DW'(7 * BAR_STEP) : '0;
    endcase
    sum = {1'b0, pat} + (DW+1)'(PEDE);
    lvl = DW'(PEDE);
    if (s1_sync)
      lvl = '0;
    else if (s1_act)
      lvl = sum[DW] ? '1 : sum[DW-1:0];
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      VIDEOs_o      <= DW'(PEDE);
      XSYNC_o       <= 1'b1;
      XBLK_o        <= 1'b0;
      FCTRs_o       <= '0;
      FRAME_START_o <= 1'b0;
    end else if (CK_EE_i) begin
      VIDEOs_o      <= lvl;
      XSYNC_o       <= ~s1_sync;
      XBLK_o        <= s1_act;
      FCTRs_o       <= s1_f;
      FRAME_START_o <= s1_first;
    end
  end

  logic [DW:0] acc;

  // The modulator runs on every clock so the DAC never stalls.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      acc     <= '0;
      VIDEO_o <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[DW-1:0]} + {1'b0, VIDEOs_o};
      VIDEO_o <= acc[DW];
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a reduced raster,
// plus a tiny-raster instance for frame-counter wrap.
module tb_video_pattern_gen;

  localparam int HT  = 100;
  localparam int VT  = 30;
  localparam int HS  = 8;
  localparam int HAS = 20;
  localparam int HAL = 64;
  localparam int VS  = 3;
  localparam int VAS = 5;
  localparam int VAL = 20;

  typedef struct packed {
    logic [9:0] video;
    logic       xsync;
    logic       xblk;
    logic [7:0] fctr;
    logic       fs;
  } smp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ee = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [9:0] level = 10'd0;
  logic [9:0] videos;
  logic       video;
  logic       xsync;
  logic       xblk;
  logic [7:0] fctrs;
  logic       fs;

  video_pattern_gen #(
    .DW(10), .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS),
    .H_ACT_START(HAS), .H_ACT_LEN(HAL), .V_SYNC(VS),
    .V_ACT_START(VAS), .V_ACT_LEN(VAL), .PEDE(205),
    .BAR_STEP(85)
  ) dut (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ee),
    .MODE_i(mode), .LEVEL_i(level),
    .VIDEOs_o(videos), .VIDEO_o(video),
    .XSYNC_o(xsync), .XBLK_o(xblk),
    .FCTRs_o(fctrs), .FRAME_START_o(fs)
  );

  logic       rst_b = 1'b1;
  logic       ee_b = 1'b0;
  logic [1:0] mode_b = 2'd0;
  logic [9:0] level_b = 10'd0;
  logic [9:0] videos_b;
  logic       video_b;
  logic       xsync_b;
  logic       xblk_b;
  logic [7:0] fctrs_b;
  logic       fs_b;

  video_pattern_gen #(
    .DW(10), .H_TOTAL(16), .V_TOTAL(4), .H_SYNC(2),
    .H_ACT_START(4), .H_ACT_LEN(8), .V_SYNC(1),
    .V_ACT_START(1), .V_ACT_LEN(2), .PEDE(205),
    .BAR_STEP(85)
  ) dut_b (
    .CK_i(clk), .RST_i(rst_b), .CK_EE_i(ee_b),
    .MODE_i(mode_b), .LEVEL_i(level_b),
    .VIDEOs_o(videos_b), .VIDEO_o(video_b),
    .XSYNC_o(xsync_b), .XBLK_o(xblk_b),
    .FCTRs_o(fctrs_b), .FRAME_START_o(fs_b)
  );

  int checks = 0;
  int failures = 0;
  smp_t q[$];
  int mh, mv, mf, fr, tick;
  logic [1:0] mmode;
  int en_cnt = 0;
  logic last_en = 1'b0;
  int bar_p [8] = '{0, 85, 170, 255, 340, 425, 510, 595};

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic smp_t expect_at(int h, int v, int f,
                                     logic [1:0] m, int lvl);
    smp_t s;
    int x, y, p, lv;
    x = h - HAS;
    y = v - VAS;
    p = 0;
    s.xsync = (v < VS) ? !(h < HT - HS) : !(h < HS);
    s.xblk = (h >= HAS) && (h < HAS + HAL) &&
             (v >= VAS) && (v < VAS + VAL);
    if (s.xblk) begin
      case (m)
        2'd0: p = (((x / 2) + y + f) % 256) * 2;
        2'd1: p = bar_p[x / (HAL / 8)];
        2'd2: p = lvl;
        default: p = (((x >> 5) ^ (y >> 5) ^ f) & 1) ? 595 : 0;
      endcase
    end
    if (!s.xsync) lv = 0;
    else if (!s.xblk) lv = 205;
    else lv = (205 + p > 1023) ? 1023 : 205 + p;
    s.video = 10'(lv);
    s.fctr = 8'(f);
    s.fs = (h == 0) && (v == 0);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      en_cnt <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= ee;
      if (ee && en_cnt < 2) en_cnt <= en_cnt + 1;
    end
  end

  always @(negedge clk) begin
    smp_t e, g;
    if (last_en && en_cnt >= 2) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got=empty exp=sample");
      end else begin
        e = q.pop_front();
        g.video = videos;
        g.xsync = xsync;
        g.xblk = xblk;
        g.fctr = fctrs;
        g.fs = fs;
        if (g !== e) begin
          failures++;
          $display("FAIL sample got=%0d/%b/%b/%0d/%b exp=%0d/%b/%b/%0d/%b",
                   g.video, g.xsync, g.xblk, g.fctr, g.fs,
                   e.video, e.xsync, e.xblk, e.fctr, e.fs);
        end
      end
    end
  end

  task automatic plan();
    case (fr)
      0: begin mode = (mv >= 15) ? 2'd2 : 2'd1; level = 10'd1023; end
      1: begin mode = 2'd2; level = (mv >= 28) ? 10'd100 : 10'd1023; end
      2: begin mode = (mv >= 28) ? 2'd0 : 2'd2; level = 10'd100; end
      3: mode = (mv >= 10) ? 2'd3 : 2'd0;
      default: mode = 2'd3;
    endcase
  endtask

  task automatic cyc();
    @(negedge clk);
    ee = (tick % 7) != 3;
    tick++;
    plan();
    if (ee) begin
      if (mh == 0 && mv == 0) mmode = mode;
      q.push_back(expect_at(mh, mv, mf, mmode, int'(level)));
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) begin
          mv = 0;
          mf = (mf + 1) % 256;
          fr++;
        end
      end
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_videos"}, int'(videos), 205);
    chk({tag, "_xsync"}, int'(xsync), 1);
    chk({tag, "_xblk"}, int'(xblk), 0);
    chk({tag, "_fctr"}, int'(fctrs), 0);
    chk({tag, "_fs"}, int'(fs), 0);
    chk({tag, "_video"}, int'(video), 0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    ee = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    mh = 0; mv = 0; mf = 0; fr = 0; mmode = 2'd0;
    repeat (10) @(negedge clk);
    check_reset_vals(tag);
    rst = 1'b0;
  endtask

  initial begin
    int ones, k, last, c;
    tick = 0;
    do_reset("rst");
    ones = 0;
    for (int i = 0; i < 1028; i++) begin
      @(negedge clk);
      if (i == 0) chk("ds_start", int'(video), 0);
      if (i >= 2 && i < 1026) ones += int'(video);
    end
    chk("hold_videos", int'(videos), 205);
    chk("hold_xsync", int'(xsync), 1);
    chk("hold_xblk", int'(xblk), 0);
    chk("hold_fs", int'(fs), 0);
    chk("ds_density_ok", int'(ones >= 204 && ones <= 206), 1);

    while (!(fr == 6 && mv == 12) && tick < 40000) cyc();
    chk("run_reached_frame6", fr, 6);

    do_reset("midrst");
    for (int i = 0; i < 3600; i++) cyc();
    @(negedge clk);
    ee = 1'b0;

    @(negedge clk);
    rst_b = 1'b0;
    ee_b = 1'b1;
    k = 0;
    last = -1;
    for (c = 0; c < 64 * 258 + 8; c++) begin
      @(negedge clk);
      if (fs_b) begin
        chk("fctr_wrap", int'(fctrs_b), k % 256);
        if (last >= 0) chk("fs_period", c - last, 64);
        last = c;
        k++;
      end
    end
    chk("fs_count", k, 259);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Parametrised composite-video test-pattern generator: a built-in H/V/frame timing counter drives sync, blanking and one of four selectable active-area patterns, producing a DW-bit video level plus a 1-bit delta-sigma DAC output. It generalises the fixed 263-line ramp generator to configurable raster geometry, output width and pattern mode, with per-frame mode latching, output saturation and an integrated DAC modulator. It sits between the system clock/enable and the video output pin / R-2R DAC.

## Interface
Parameters:
- DW, 10: video sample width (must be ≥ 9).
- H_TOTAL, 780: clocks per line.
- V_TOTAL, 263: lines per frame (non-interlaced).
- H_SYNC, 58: H-sync pulse length, clocks.
- H_ACT_START, 128; H_ACT_LEN, 640: active pixels; H_ACT_LEN is a multiple of 8.
- V_SYNC, 3: V-sync lines.
- V_ACT_START, 21; V_ACT_LEN, 240: active lines.
- PEDE, 205: blanking/black level.
- BAR_STEP, 85: gray-bar increment.

Ports:
- CK_i  in  1  system clock, 12.27272 MHz.
- RST_i  in  1  synchronous, active-high reset.
- CK_EE_i  in  1  pixel clock enable; all raster logic advances only when high.
- MODE_i  in  2  pattern select: 0 moving ramp, 1 gray bars, 2 flat, 3 checker.
- LEVEL_i  in  DW  flat-mode pattern code.
- VIDEOs_o  out  DW  video level (0 = sync tip).
- VIDEO_o  out  1  delta-sigma bitstream of VIDEOs_o.
- XSYNC_o  out  1  composite sync, active low.
- XBLK_o  out  1  low during blanking.
- FCTRs_o  out  8  frame counter.
- FRAME_START_o  out  1  marks the sample of raster position (0,0).

## Operation
- Counters (advance on enabled cycles): HCTR 0..H_TOTAL-1; at wrap VCTR increments, 0..V_TOTAL-1; at frame wrap FCTR increments, 8-bit, 255→0.
- Mode latch: MODE_i is captured into MODE_L on the enabled cycle where HCTR=0 and VCTR=0. A mid-frame MODE_i change takes effect at the next frame only.
- Sync: on lines VCTR<V_SYNC, XSYNC is low for HCTR<H_TOTAL-H_SYNC (broad pulse); on other lines, XSYNC is low for HCTR<H_SYNC.
- Active: HCTR in [H_ACT_START, H_ACT_START+H_ACT_LEN) and VCTR in [V_ACT_START, V_ACT_START+V_ACT_LEN). x = HCTR-H_ACT_START and y = VCTR-V_ACT_START. XBLK is high only when active.
- Pattern code P (DW bits):
  - Mode 0: ((x>>1)+y+FCTR) mod 256, shifted left 1.
  - Mode 1: bar index b (0..7) from a sub-counter stepping every H_ACT_LEN/8 pixels, reset at x=0; P = b·BAR_STEP.
  - Mode 2: P = LEVEL_i.
  - Mode 3: P = (x[5]^y[5]^FCTR[0]) ? 7·BAR_STEP : 0.
- Level priority:
  - ~XSYNC → 0.
  - else ~XBLK → PEDE.
  - else PEDE+P, saturated to 2^DW-1. The sum is computed at DW+1 bits.
- Delta-sigma: accumulator ACC of DW+1 bits, updated every CK_i cycle (not gated by CK_EE_i): ACC ← {0,ACC[DW-1:0]} + VIDEOs_o. VIDEO_o = ACC[DW], registered.

## Timing
- Pipeline: the sample for counter position (h,v) appears on VIDEOs_o, XSYNC_o and XBLK_o two enabled cycles after the counters hold (h,v). All three are aligned.
- FCTRs_o is registered with the same two-stage alignment; it changes with the (0,0) sample.
- FRAME_START_o is high for exactly one enabled period: from the enable edge that presents the (0,0) sample until the next enable edge.
- With CK_EE_i low, all raster state and outputs hold; only ACC/VIDEO_o run.
- Reset (RST_i high at a CK_i edge, regardless of CK_EE_i; applies identically mid-frame):
  - HCTR=VCTR=FCTR=0, MODE_L=0, pipeline cleared.
  - VIDEOs_o=PEDE, XSYNC_o=1, XBLK_o=0, FCTRs_o=0, FRAME_START_o=0.
  - ACC=0, VIDEO_o=0.
- First enabled cycle after reset release: counters are at (0,0); MODE_i is latched then.

## Test plan
- Reset/hold: RST_i high 10 cycles, then low with CK_EE_i=0 → outputs stay at reset values: VIDEOs_o=205, XSYNC_o=1, XBLK_o=0, VIDEO_o=0.
- Raster geometry, CK_EE_i=1:
  - FRAME_START_o pulses every 780·263=205140 cycles.
  - FCTRs_o reaches 255 and wraps to 0.
  - XSYNC_o low 58 clocks per normal line and 722 clocks on lines 0-2.
  - XBLK_o high 640 clocks on lines 21-260 only.
- Gray bars, MODE_i=1: active line shows 8 runs of 80 samples at 205, 290, …, 800. Blanking is 205 and sync is 0.
- Saturation: MODE_i=2, LEVEL_i=1023 → active samples = 1023. LEVEL_i=100 → 305.
- Mode latch: switch MODE_i 0→3 at line 100 → the current frame stays ramp; the next frame is checker with levels 205/800, with phase inverted on alternate frames.
- Delta-sigma: hold VIDEOs_o at 205 (blanking) → VIDEO_o has ones density 205/1024 ±1 over 1024 cycles.
